rgbw_srx: RTL
=============

Name: rgbw_srx

Overview:
- Serial receiver for the SK6812RGBW single-wire stream that rgb_sotp transmits. It is the decoding end of that interface.
- Measures high-pulse widths to recover bits, assembles them MSB-first into 32-bit words, and detects the long-low stream reset.
- Used as an on-chip loopback checker and in benches to verify rgb_sotp output word-for-word against the original data.

Parameters:
- SAMPLE_TIME_CLKS, 30: high-time threshold. High time >= this gives bit 1, otherwise bit 0. Sits between RGBW_T0H=16 and RGBW_T1H=45.
- STREAM_RESET_CLKS, 4800: continuous low clocks that constitute a stream reset.
- MAX_HIGH_CLKS, 100: high time at or above this is a protocol error.
- COUNTER_MAX, 7800: saturation value of the pulse counter. Counter width is $clog2(COUNTER_MAX+1).
- WORD_BITS, 32: bits per word.

Ports:
- clk  in  1  system clock (96 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- sig  in  1  serial RGBW line, asynchronous to clk
- out_word  out  WORD_BITS  last completed word; first received bit lands in bit [WORD_BITS-1]
- out_strobe  out  1  one-clock pulse when out_word is updated
- out_stream_reset  out  1  one-clock pulse when a stream reset is detected
- out_err  out  1  one-clock pulse on a protocol error
- out_synced  out  1  high while decoding is enabled

Behaviour:
- Input path: sig passes through a 2-flop synchronizer (s1, s2), plus a delay flop s3 for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - All decoding uses s2 only.
- Reset (asynchronous): out_word=0, out_strobe=0, out_stream_reset=0, out_err=0, out_synced=0. s1/s2/s3, counter, shift register and bit count all clear. State = WAIT_RST.
- Counter: counts consecutive clocks s2 has held its current level.
  - Loads 1 on the cycle s2 changes level; increments otherwise.
  - Saturates at COUNTER_MAX and never wraps.
- State WAIT_RST (out_synced=0): bits are not decoded.
  - When s2=0 and the counter reaches STREAM_RESET_CLKS, pulse out_stream_reset and go to LOW.
- State LOW (out_synced=1):
  - On rise, go to HIGH.
  - If the counter reaches STREAM_RESET_CLKS while s2=0, pulse out_stream_reset and stay in LOW.
  - If bit_cnt != 0 at that point, also pulse out_err in the same cycle, discard the partial word and clear bit_cnt.
  - Only the cycle where count equals STREAM_RESET_CLKS pulses. A saturated low line gives no repeat pulses.
- State HIGH (out_synced=1):
  - On fall, the bit value is (count_at_fall >= SAMPLE_TIME_CLKS); shift it in and increment bit_cnt, then go to LOW.
  - When this fall completes bit WORD_BITS: in that same registered update, out_word takes the full word, out_strobe pulses, and bit_cnt goes to 0.
  - If the counter reaches MAX_HIGH_CLKS while s2=1, pulse out_err, discard the partial word and go to WAIT_RST.
- Latency: let edge k be the first clk edge that samples sig low after the final bit's high. Decode registers update on edge k+2, so out_strobe is high in the cycle after edge k+2. Stream-reset detection has the same 2-edge offset.
- Measured high time equals the number of clk edges that sampled sig high; there is no ±1 skew.
- Simultaneous events: out_strobe and out_stream_reset cannot coincide, because a stream reset requires STREAM_RESET_CLKS of low after any fall. out_err and out_stream_reset may coincide (partial-word case).
- Bit timing: gaps between bits may be any length below STREAM_RESET_CLKS. No minimum low time is enforced.
- Reset mid-word: every output and all internal state clears immediately. Decoding resumes only after a full stream reset.
- out_word holds its value until the next completed word. Stream resets and errors do not clear it.

Test Plan:
1. After rst, hold sig low 4800 clks, then send 0xA5C30F81 with T0H/T0L=16/74 and T1H/T1L=45/45 -> one out_stream_reset pulse and out_synced=1, then exactly one out_strobe with out_word=0xA5C30F81, 2 clks after the last fall.
2. Immediately after rst (no preceding low period), send 32 bits of 0xFFFFFFFF -> no out_strobe, out_synced stays 0. Then hold low 4800 clks -> out_stream_reset fires.
3. After sync, send 32 bits whose high times alternate 30,29,30,29,... clks with 60-clk lows -> out_word=0xAAAAAAAA.
4. After sync, send 20 bits, then hold low 4800 clks -> out_err and out_stream_reset pulse in the same cycle, no out_strobe. Then send 0x00000001 -> out_strobe with out_word=0x00000001.
5. After sync, hold sig high 100 clks -> out_err pulses once and out_synced drops to 0. A following 32-bit word produces no strobe until low for 4800 clks, after which the next word decodes.
6. After sync and 10 bits sent, assert rst for 3 clks mid-pulse -> all outputs 0 immediately and out_synced=0. After a stream reset and a full word, out_word equals the new word with no stale bits.

Source files
------------

// File: rtl/rgbw_srx.sv
// rgbw_srx: SK6812RGBW single-wire stream receiver.
// Recovers bits from high-pulse widths, packs them MSB-first into words and
// flags the long-low stream reset. Decoding starts only after a stream reset.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   sig               serial line, asynchronous to clk
//   out_word          last completed word (first bit received in the MSB)
//   out_strobe        one-clock pulse when out_word updates
//   out_stream_reset  one-clock pulse on stream reset detection
//   out_err           one-clock pulse on protocol error
//   out_synced        high while decoding is enabled
module rgbw_srx #(
  parameter int unsigned SAMPLE_TIME_CLKS  = 30,
  parameter int unsigned STREAM_RESET_CLKS = 4800,
  parameter int unsigned MAX_HIGH_CLKS     = 100,
  parameter int unsigned COUNTER_MAX       = 7800,
  parameter int unsigned WORD_BITS         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig,
  output logic [WORD_BITS-1:0] out_word,
  output logic                 out_strobe,
  output logic                 out_stream_reset,
  output logic                 out_err,
  output logic                 out_synced
);

  localparam int unsigned CW = $clog2(COUNTER_MAX + 1);
  localparam int unsigned BW = $clog2(WORD_BITS + 1);

  typedef enum logic [1:0] {WAIT_RST, LOW, HIGH} state_t;

  state_t               state, state_nxt;
  logic                 s1, s2, s3;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [WORD_BITS-2:0] shreg;

  logic rise_c, fall_c, low_reset_c, high_err_c, bit_val_c, last_bit_c;
  logic sr_c, err_c, shift_c, clr_c;

  // Synchronizer plus delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;
  assign fall_c = ~s2 & s3;

  // Run-length of the current s2 level, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise_c || fall_c) begin
      cnt <= CW'(1);
    end else if (cnt != CW'(COUNTER_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // On a fall cycle cnt still holds the completed high width, so it is the
  // measured value for both the bit decision and the over-long check.
  assign low_reset_c = ~s2 & ~fall_c & (cnt == CW'(STREAM_RESET_CLKS));
  assign high_err_c  = (cnt >= CW'(MAX_HIGH_CLKS));
  assign bit_val_c   = (cnt >= CW'(SAMPLE_TIME_CLKS));
  assign last_bit_c  = (bit_cnt == BW'(WORD_BITS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_RST;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_RST: if (low_reset_c) state_nxt = LOW;
      LOW:      if (rise_c) state_nxt = HIGH;
      HIGH: begin
        if (high_err_c)  state_nxt = WAIT_RST;
        else if (fall_c) state_nxt = LOW;
      end
      default:  state_nxt = WAIT_RST;
    endcase
  end

  // Decode actions for the datapath
  always_comb begin
    sr_c    = 1'b0;
    err_c   = 1'b0;
    shift_c = 1'b0;
    clr_c   = 1'b0;
    unique case (state)
      WAIT_RST: sr_c = low_reset_c;
      LOW: begin
        if (!rise_c && low_reset_c) begin
          sr_c = 1'b1;
          if (bit_cnt != '0) begin
            err_c = 1'b1;
            clr_c = 1'b1;
          end
        end
      end
      HIGH: begin
        if (high_err_c) begin
          err_c = 1'b1;
          clr_c = 1'b1;
        end else if (fall_c) begin
          shift_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shift register, bit counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg            <= '0;
      bit_cnt          <= '0;
      out_word         <= '0;
      out_strobe       <= 1'b0;
      out_stream_reset <= 1'b0;
      out_err          <= 1'b0;
      out_synced       <= 1'b0;
    end else begin
      out_strobe       <= 1'b0;
      out_stream_reset <= sr_c;
      out_err          <= err_c;
      out_synced       <= (state_nxt != WAIT_RST);
      if (clr_c) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (shift_c) begin
        if (last_bit_c) begin
          out_word   <= {shreg, bit_val_c};
          out_strobe <= 1'b1;
          shreg      <= '0;
          bit_cnt    <= '0;
        end else begin
          shreg   <= {shreg[WORD_BITS-3:0], bit_val_c};
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

endmodule
